instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 186 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 field-to-word instruction encoder with pc tracking and output register
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        done,
  output logic [15:0] count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  logic        accept, out_fire;
  logic        illegal, bad_imm;
  logic [31:0] word;
  logic        fits12, fits13, fits21;

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign done      = done_q;
  assign count     = count_q;

  // Signed range checks: all bits above the field width must equal its sign bit.
  assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    illegal = 1'b0;
    bad_imm = 1'b0;
    word    = '0;
    case (opcode)
      OP_R: begin
        illegal = !(funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
        word    = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          illegal = !(funct7 == 7'h00 || (funct7 == 7'h20 && funct3 == 3'b101));
          bad_imm = |imm[31:5];
          word    = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          bad_imm = !fits12;
          word    = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      OP_LOAD: begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        bad_imm = !fits12;
        word    = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_JALR: begin
        illegal = (funct3 != 3'b000);
        bad_imm = !fits12;
        word    = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_STORE: begin
        illegal = (funct3 > 3'b010);
        bad_imm = !fits12;
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      OP_BR: begin
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
        bad_imm = !fits13 || imm[0];
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      OP_JAL: begin
        bad_imm = !fits21 || imm[0];
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    count_d     = count_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = base_pc & 32'hFFFF_FFFC;
          count_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (illegal || bad_imm) begin
            err_d      = 1'b1;
            err_code_d = illegal ? 2'b01 : 2'b10;
          end else begin
            instr_d     = word;
            addr_d      = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
          end
          if (in_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_pc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr, addr;
  logic        err;
  logic [1:0]  err_code;
  logic        done;
  logic [15:0] count;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .err(err), .err_code(err_code), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        last;
    logic [1:0]  ecode;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [26];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  logic [1:0]  last_code;
  int          exp_count;

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im, input logic last, input logic [1:0] ec,
                              input logic [31:0] ex);
    vec_t v;
    v.op = op; v.rd = a; v.rs1 = b; v.rs2 = c; v.f3 = f3; v.f7 = f7;
    v.imm = im; v.last = last; v.ecode = ec; v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm; in_last = v.last;
    in_valid = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] bp);
    start = 1'b1; base_pc = bp;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams vectors back-to-back, one per cycle, checking each result one cycle after acceptance.
  task automatic stream(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vt[i]);
      @(negedge clk);
      chk($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (vt[i].ecode == 2'b00) begin
        chk($sformatf("instr[%0d]", i), instr, vt[i].exp);
        chk($sformatf("addr[%0d]", i), addr, exp_pc);
        chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'd1);
        chk($sformatf("err[%0d]", i), 32'(err), 32'd0);
        exp_pc = exp_pc + 32'd4;
        exp_count++;
      end else begin
        chk($sformatf("err[%0d]", i), 32'(err), 32'd1);
        chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'd0);
        last_code = vt[i].ecode;
      end
      chk($sformatf("err_code[%0d]", i), 32'(err_code), 32'(last_code));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,         1'b0, 2'b00, 32'h00500093);
    vt[1]  = mk(7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'd0,         1'b0, 2'b00, 32'h002081B3);
    vt[2]  = mk(7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h00, 32'd8,         1'b0, 2'b00, 32'h0020A423);
    vt[3]  = mk(7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFC,  1'b0, 2'b00, 32'hFE000EE3);
    vt[4]  = mk(7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2048,      1'b0, 2'b10, 32'h0);
    vt[5]  = mk(7'h7F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd0,         1'b0, 2'b01, 32'h0);
    vt[6]  = mk(7'h33, 5'd5,  5'd6,  5'd7,  3'd0, 7'h20, 32'd0,         1'b0, 2'b00, 32'h407302B3);
    vt[7]  = mk(7'h33, 5'd5,  5'd6,  5'd7,  3'd1, 7'h20, 32'd0,         1'b0, 2'b01, 32'h0);
    vt[8]  = mk(7'h13, 5'd1,  5'd2,  5'd0,  3'd5, 7'h20, 32'd31,        1'b0, 2'b00, 32'h41F15093);
    vt[9]  = mk(7'h13, 5'd1,  5'd2,  5'd0,  3'd1, 7'h00, 32'd32,        1'b0, 2'b10, 32'h0);
    vt[10] = mk(7'h13, 5'd1,  5'd2,  5'd0,  3'd1, 7'h20, 32'd3,         1'b0, 2'b01, 32'h0);
    vt[11] = mk(7'h03, 5'd4,  5'd5,  5'd0,  3'd2, 7'h00, 32'hFFFFFFFF,  1'b0, 2'b00, 32'hFFF2A203);
    vt[12] = mk(7'h03, 5'd4,  5'd5,  5'd0,  3'd3, 7'h00, 32'd0,         1'b0, 2'b01, 32'h0);
    vt[13] = mk(7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFF800,  1'b0, 2'b00, 32'h80000093);
    vt[14] = mk(7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF7FF,  1'b0, 2'b10, 32'h0);
    vt[15] = mk(7'h67, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'd0,         1'b0, 2'b00, 32'h00008067);
    vt[16] = mk(7'h67, 5'd0,  5'd1,  5'd0,  3'd1, 7'h00, 32'd0,         1'b0, 2'b01, 32'h0);
    vt[17] = mk(7'h23, 5'd0,  5'd1,  5'd2,  3'd3, 7'h00, 32'd0,         1'b0, 2'b01, 32'h0);
    vt[18] = mk(7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4094,      1'b0, 2'b00, 32'h7E000FE3);
    vt[19] = mk(7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4096,      1'b0, 2'b10, 32'h0);
    vt[20] = mk(7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd3,         1'b0, 2'b10, 32'h0);
    vt[21] = mk(7'h63, 5'd0,  5'd0,  5'd0,  3'd2, 7'h00, 32'd8,         1'b0, 2'b01, 32'h0);
    vt[22] = mk(7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd3,         1'b0, 2'b10, 32'h0);
    vt[23] = mk(7'h6F, 5'd0,  5'd5,  5'd6,  3'd7, 7'h7F, 32'hFFF00000,  1'b0, 2'b00, 32'h8000006F);
    vt[24] = mk(7'h23, 5'd0,  5'd10, 5'd31, 3'd0, 7'h00, 32'hFFFFF800,  1'b0, 2'b00, 32'h81F50023);
    vt[25] = mk(7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2048,      1'b1, 2'b00, 32'h001000EF);

    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst instr",     instr,          32'd0);
    chk("rst addr",      addr,           32'd0);
    chk("rst err",       32'(err),       32'd0);
    chk("rst err_code",  32'(err_code),  32'd0);
    chk("rst done",      32'(done),      32'd0);
    chk("rst count",     32'(count),     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", 32'(in_ready), 32'd0);

    do_start(32'h100);
    exp_pc = 32'h100; last_code = 2'b00; exp_count = 0;
    stream(0, 25);
    begin
      int k = 0;
      while (!done && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("done after last", 32'(done), 32'd1);
    chk("count at done", 32'(count), 32'(exp_count));
    chk("done in_ready", 32'(in_ready), 32'd0);
    chk("done out_valid", 32'(out_valid), 32'd0);

    do_start(32'h203);
    chk("restart count", 32'(count), 32'd0);
    chk("restart done", 32'(done), 32'd0);
    out_ready = 1'b0;
    drive(vt[0]);
    @(posedge clk); #1;
    drive(vt[1]);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp instr", instr, 32'h00500093);
    chk("bp addr", addr, 32'h200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold in_ready[%0d]", c), 32'(in_ready), 32'd0);
      chk($sformatf("hold out_valid[%0d]", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold instr[%0d]", c), instr, 32'h00500093);
      chk($sformatf("hold addr[%0d]", c), addr, 32'h200);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second instr", instr, 32'h002081B3);
    chk("second addr", addr, 32'h204);
    chk("second out_valid", 32'(out_valid), 32'd1);
    chk("count after first", 32'(count), 32'd1);

    drive(vt[2]);
    start = 1'b1; base_pc = 32'h800;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("ignored start addr", addr, 32'h208);
    chk("ignored start instr", instr, 32'h0020A423);
    chk("ignored start count", 32'(count), 32'd2);

    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd0);
    chk("async instr", instr, 32'd0);
    chk("async addr", addr, 32'd0);
    chk("async count", 32'(count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    chk("post-rst in_ready", 32'(in_ready), 32'd0);

    do_start(32'h1000);
    exp_pc = 32'h1000; last_code = 2'b00;
    stream(0, 0);
    @(posedge clk); #1;
    chk("final count", 32'(count), 32'd1);
    chk("final out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
